alu_issue: RTL and testbench

// Issue/decode front end for the combinational alu: accepts RV32 R-/I-type ALU

---
 rtl/alu_issue.sv | 138 +++++++++++++
 tb/tb_alu_issue.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// Issue/decode front end for a combinational RV32 ALU: decodes ADD/AND/SLL/XOR (R and I forms),
// drives the ALU from registers, and hands back a registered result on a valid/ready pair.
module alu_issue #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rs1_val,
    input  logic [DATA_W-1:0] rs2_val,
    output logic [DATA_W-1:0] alu_in0,
    output logic [DATA_W-1:0] alu_in1,
    output logic [2:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_zero,
    output logic [4:0]        res_rd,
    output logic              res_illegal,
    output logic [CNT_W-1:0]  retired_cnt
);
    // Selector encodings of the alu's add/and/sll/xor operations
    localparam logic [2:0] SEL_ADD = 3'd0;
    localparam logic [2:0] SEL_AND = 3'd1;
    localparam logic [2:0] SEL_SLL = 3'd2;
    localparam logic [2:0] SEL_XOR = 3'd3;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t state, state_nxt;
    logic   accept, handoff;
    logic   rd_ill;
    logic [4:0] rd_q;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [DATA_W-1:0] dec_in0, dec_in1;
    logic [2:0] dec_sel;
    logic       dec_ill;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    assign accept  = in_valid & in_ready;
    assign handoff = res_valid & res_ready;

    // Illegal ops feed add(0,0) so the ALU sees a harmless, known operation
    always_comb begin
        dec_in0 = '0;
        dec_in1 = '0;
        dec_sel = SEL_ADD;
        dec_ill = 1'b1;
        case (funct3)
            3'b000:  dec_sel = SEL_ADD;
            3'b111:  dec_sel = SEL_AND;
            3'b001:  dec_sel = SEL_SLL;
            3'b100:  dec_sel = SEL_XOR;
            default: dec_sel = SEL_ADD;
        endcase
        if (funct3 == 3'b000 || funct3 == 3'b111 || funct3 == 3'b001 || funct3 == 3'b100) begin
            if (opcode == 7'b0110011 && funct7 == 7'd0) begin
                dec_ill = 1'b0;
                dec_in1 = rs2_val;
            end else if (opcode == 7'b0010011) begin
                if (funct3 == 3'b001) begin
                    dec_ill = (funct7 != 7'd0);
                    dec_in1 = {{(DATA_W-5){1'b0}}, instr[24:20]};
                end else begin
                    dec_ill = 1'b0;
                    dec_in1 = {{(DATA_W-12){instr[31]}}, instr[31:20]};
                end
            end
        end
        if (dec_ill) begin
            dec_in1 = '0;
            dec_sel = SEL_ADD;
        end else begin
            dec_in0 = rs1_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = in_valid ? EXEC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) || (state == DONE && res_ready);
        res_valid = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_in0     <= '0;
            alu_in1     <= '0;
            alu_sel     <= SEL_ADD;
            rd_q        <= '0;
            rd_ill      <= 1'b0;
            res_data    <= '0;
            res_zero    <= 1'b0;
            res_rd      <= '0;
            res_illegal <= 1'b0;
            retired_cnt <= '0;
        end else begin
            if (accept) begin
                alu_in0 <= dec_in0;
                alu_in1 <= dec_in1;
                alu_sel <= dec_sel;
                rd_q    <= instr[11:7];
                rd_ill  <= dec_ill;
            end
            if (state == EXEC) begin
                res_data    <= rd_ill ? '0 : alu_out;
                res_zero    <= rd_ill ? 1'b0 : alu_zero;
                res_rd      <= rd_q;
                res_illegal <= rd_ill;
            end
            if (handoff && !res_illegal)
                retired_cnt <= retired_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural combinational ALU hooked to its alu_* ports.
module tb_alu_issue;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;
    localparam logic [2:0] SEL_ADD = 3'd0;
    localparam logic [2:0] SEL_AND = 3'd1;
    localparam logic [2:0] SEL_SLL = 3'd2;
    localparam logic [2:0] SEL_XOR = 3'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0, in_ready;
    logic [31:0] instr = '0;
    logic [DATA_W-1:0] rs1_val = '0, rs2_val = '0;
    logic [DATA_W-1:0] alu_in0, alu_in1, alu_out;
    logic [2:0] alu_sel;
    logic alu_zero;
    logic res_valid, res_ready = 1'b0;
    logic [DATA_W-1:0] res_data;
    logic res_zero, res_illegal;
    logic [4:0] res_rd;
    logic [CNT_W-1:0] retired_cnt;

    int checks = 0;
    int errors = 0;

    alu_issue #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_zero(alu_zero),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_zero(res_zero), .res_rd(res_rd), .res_illegal(res_illegal),
        .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_sel)
            SEL_ADD: alu_out = alu_in0 + alu_in1;
            SEL_AND: alu_out = alu_in0 & alu_in1;
            SEL_SLL: alu_out = alu_in0 << alu_in1[4:0];
            SEL_XOR: alu_out = alu_in0 ^ alu_in1;
            default: alu_out = '0;
        endcase
        alu_zero = (alu_out == '0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        instr = i; rs1_val = a; rs2_val = b; in_valid = 1'b1;
    endtask

    // accept edge, then capture edge; leaves the block in DONE
    task automatic issue(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        drive(i, a, b);
        cyc();
        in_valid = 1'b0;
        cyc();
    endtask

    task automatic take();
        res_ready = 1'b1;
        cyc();
        res_ready = 1'b0;
    endtask

    initial begin
        repeat (2) cyc();
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_alu_sel", {29'd0, alu_sel}, {29'd0, SEL_ADD});
        chk("rst_cnt", {16'd0, retired_cnt}, 32'd0);
        rst = 1'b0;
        cyc();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // ADD x3 = 5 + 5
        drive(32'h002081B3, 32'd5, 32'd5);
        cyc();
        in_valid = 1'b0;
        chk("add_exec_valid", {31'd0, res_valid}, 32'd0);
        chk("add_exec_ready", {31'd0, in_ready}, 32'd0);
        chk("add_in0", alu_in0, 32'd5);
        chk("add_in1", alu_in1, 32'd5);
        chk("add_sel", {29'd0, alu_sel}, {29'd0, SEL_ADD});
        cyc();
        chk("add_valid", {31'd0, res_valid}, 32'd1);
        chk("add_data", res_data, 32'd10);
        chk("add_zero", {31'd0, res_zero}, 32'd0);
        chk("add_rd", {27'd0, res_rd}, 32'd3);
        chk("add_cnt_pre", {16'd0, retired_cnt}, 32'd0);
        take();
        chk("add_cnt", {16'd0, retired_cnt}, 32'd1);
        chk("add_idle_valid", {31'd0, res_valid}, 32'd0);
        chk("add_idle_ready", {31'd0, in_ready}, 32'd1);

        // ANDI x5 = 6 & 1
        issue(32'h0010F293, 32'd6, 32'd0);
        chk("andi_data", res_data, 32'd0);
        chk("andi_zero", {31'd0, res_zero}, 32'd1);
        chk("andi_rd", {27'd0, res_rd}, 32'd5);
        take();
        chk("andi_cnt", {16'd0, retired_cnt}, 32'd2);

        // SLLI x1 = 5 << 1
        drive(32'h00109093, 32'd5, 32'hDEAD);
        cyc();
        in_valid = 1'b0;
        chk("slli_sel", {29'd0, alu_sel}, {29'd0, SEL_SLL});
        chk("slli_in1", alu_in1, 32'd1);
        cyc();
        chk("slli_data", res_data, 32'd10);
        chk("slli_rd", {27'd0, res_rd}, 32'd1);
        take();
        chk("slli_cnt", {16'd0, retired_cnt}, 32'd3);

        // ADDI x1 = 1 + (-1): sign-extended immediate
        drive(32'hFFF08093, 32'd1, 32'd0);
        cyc();
        in_valid = 1'b0;
        chk("addi_in1", alu_in1, 32'hFFFF_FFFF);
        cyc();
        chk("addi_data", res_data, 32'd0);
        chk("addi_zero", {31'd0, res_zero}, 32'd1);
        take();
        chk("addi_cnt", {16'd0, retired_cnt}, 32'd4);

        // SUB is unsupported
        drive(32'h40208133, 32'd7, 32'd3);
        cyc();
        in_valid = 1'b0;
        chk("sub_in0", alu_in0, 32'd0);
        chk("sub_in1", alu_in1, 32'd0);
        cyc();
        chk("sub_illegal", {31'd0, res_illegal}, 32'd1);
        chk("sub_data", res_data, 32'd0);
        chk("sub_zero", {31'd0, res_zero}, 32'd0);
        chk("sub_rd", {27'd0, res_rd}, 32'd2);
        take();
        chk("sub_cnt", {16'd0, retired_cnt}, 32'd4);

        // stall in DONE with stray in_valid, then back-to-back XORI
        issue(32'h002081B3, 32'd1, 32'd2);
        drive(32'h0010F293, 32'd9, 32'd9);
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("stall_valid", {31'd0, res_valid}, 32'd1);
            chk("stall_data", res_data, 32'd3);
            chk("stall_ready", {31'd0, in_ready}, 32'd0);
        end
        chk("stall_illegal", {31'd0, res_illegal}, 32'd0);
        drive(32'h0010C393, 32'd1, 32'd0);
        res_ready = 1'b1;
        #1;
        chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
        cyc();
        in_valid = 1'b0;
        res_ready = 1'b0;
        chk("b2b_exec_valid", {31'd0, res_valid}, 32'd0);
        chk("b2b_cnt", {16'd0, retired_cnt}, 32'd5);
        chk("xori_sel", {29'd0, alu_sel}, {29'd0, SEL_XOR});
        chk("xori_in1", alu_in1, 32'd1);
        cyc();
        chk("xori_valid", {31'd0, res_valid}, 32'd1);
        chk("xori_data", res_data, 32'd0);
        chk("xori_zero", {31'd0, res_zero}, 32'd1);
        chk("xori_rd", {27'd0, res_rd}, 32'd7);
        take();
        chk("xori_cnt", {16'd0, retired_cnt}, 32'd6);

        // async reset while an op is in EXEC
        drive(32'h002081B3, 32'd7, 32'd8);
        cyc();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, res_valid}, 32'd0);
        chk("mid_rst_cnt", {16'd0, retired_cnt}, 32'd0);
        chk("mid_rst_in0", alu_in0, 32'd0);
        chk("mid_rst_rd", {27'd0, res_rd}, 32'd0);
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
        chk("post_rst_valid", {31'd0, res_valid}, 32'd0);
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
        chk("post_rst_data", res_data, 32'd0);
        issue(32'h002081B3, 32'd7, 32'd8);
        chk("post_add_data", res_data, 32'd15);
        chk("post_add_rd", {27'd0, res_rd}, 32'd3);
        take();
        chk("post_add_cnt", {16'd0, retired_cnt}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
